rob_multi: RTL and testbench
============================

Name: rob_multi

Overview:
- Parametrised reorder buffer; successor to the single-commit, fixed-size RoB.
- Sits between the decoder/issue stage and the register file, RS and LSB.
- Entries are allocated in program order and filled by N_CDB writeback channels; up to COMMIT_W entries retire per cycle.
- Recovery is generalised: any control-flow entry whose resolved next-PC differs from its predicted next-PC triggers a flush with a redirect PC.

Parameters:
- DEPTH, 16: number of entries; power of two, at least 4.
- N_CDB, 2: number of writeback broadcast channels (RS, LSB, ...).
- COMMIT_W, 2: maximum retirements per cycle; legal values 1 or 2.
- TAG_W, $clog2(DEPTH): entry tag width (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when 0, no state changes
- issue_valid  in  1  decoder presents an instruction
- issue_ready  out  1  an entry is free and no flush is asserted this cycle
- issue_tag  out  TAG_W  tag assigned to the issuing instruction (current tail)
- issue_kind  in  2  0=ALU/writes rd, 1=LOAD, 2=STORE, 3=BRANCH (no rd)
- issue_rd  in  5  destination register; forced to 0 internally for STORE and BRANCH
- issue_pred_npc  in  32  predicted next PC
- issue_done  in  1  value known at issue (LUI, AUIPC, JAL)
- issue_value  in  32  value used when issue_done=1
- cdb_valid  in  N_CDB  per-channel writeback strobe
- cdb_tag  in  N_CDB*TAG_W  packed tags
- cdb_value  in  N_CDB*32  packed results
- cdb_npc  in  N_CDB*32  packed resolved next PC (pc+4 for non-control instructions)
- head_tag  out  TAG_W  oldest tag; LSB uses it to release stores
- commit_valid  out  COMMIT_W  per-slot retire strobe
- commit_tag  out  COMMIT_W*TAG_W  tags of retiring entries
- commit_rd  out  COMMIT_W*5  destination registers (0 means no write)
- commit_value  out  COMMIT_W*32  retire values
- q_tag1, q_tag2  in  TAG_W  operand lookup tags
- q_ready1, q_ready2  out  1  value available
- q_value1, q_value2  out  32  looked-up value
- flush  out  1  mispredict recovery strobe
- redirect_pc  out  32  correct fetch PC; 0 when flush=0

Behaviour:
- Reset: head=tail=count=0, all entries invalid. commit_valid=0, flush=0, redirect_pc=0, issue_ready=1, head_tag=0, issue_tag=0.
- Storage is a circular buffer with a count register. Full when count==DEPTH, empty when count==0. head and tail wrap modulo DEPTH.
- Issue: accepted when issue_valid && issue_ready && rdy. The tail entry is written (valid=1, done=issue_done), tail advances by 1, and issue_tag equals the pre-increment tail.
- Writeback: each channel with cdb_valid set marks its tag done and stores value and npc.
  - If two channels hit the same tag, the higher-indexed channel wins; a bench must not rely on this.
  - Writeback to an invalid entry is ignored.
  - Writeback to an entry retiring in the same cycle is ignored.
- Commit slot 0 fires when the head entry is valid and done.
- Commit slot 1 (COMMIT_W=2 only) fires when all of the following hold:
  - slot 0 fires;
  - entry head+1 is valid and done;
  - slot 0 is not mispredicting;
  - at most one of the two entries is a STORE.
- Commit outputs are combinational from current state, gated by rdy. head advances by the number of slots fired and count updates by issued minus committed.
- Mispredict: a committing entry of kind BRANCH, or with pred_npc != npc, where pred_npc != npc. This covers JALR, which is kind 0 but carries a pred_npc.
  - The mispredicting entry is still committed; its rd is written (JALR link).
  - In the same cycle flush=1 and redirect_pc=npc.
  - On that edge, all entries are invalidated and head=tail=count=0. A simultaneous issue is dropped (issue_ready=0).
- Lookup (combinational): if the entry is done, return its stored value. Otherwise, if any cdb channel matches the tag this cycle, forward that value, lowest channel first. Otherwise q_ready=0 and q_value=0.
- Simultaneous issue and commit while full: issue_ready uses the registered count only; no same-cycle slot reuse.
- rdy=0: all state is held; commit_valid=0 and flush=0.
- Reset during a flush or mid-stream takes priority and yields the reset state at the next edge.

Optional Feature:
- ROB_PERF_CNT_EN: when defined, adds three outputs, each 32 bits:
  - perf_commits: total retired entries;
  - perf_flushes: total mispredict flushes;
  - perf_full_cycles: cycles with count==DEPTH and issue_valid=1.
- All three reset to 0 and saturate at 32'hFFFFFFFF.
- When not defined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package rob_pkg holds:
  - issue_kind encodings KIND_ALU, KIND_LOAD, KIND_STORE, KIND_BRANCH;
  - an entry struct {valid, done, kind, rd, value, pred_npc, npc}.
- One sub-module, rob_cdb_match: N_CDB-way tag comparator returning hit and forwarded value. It is instantiated per lookup port and reused for writeback decode.

Test Plan:
- Reset, then issue 3 ALU entries (tags 0, 1, 2). Write back out of order (tag 2=0x33, then 0=0x11, 1=0x22) -> commits occur in order 0x11, 0x22, 0x33; with COMMIT_W=2, tags 0 and 1 retire in the same cycle.
- Fill DEPTH=16 with no writebacks -> issue_ready=0 at count 16. Write back the head -> one retire; issue_ready=1 the next cycle; tail wraps to 0.
- Issue BRANCH with pred_npc=0x100 followed by 2 ALUs; write back the branch with npc=0x200 -> flush=1, redirect_pc=0x200 on the branch's commit cycle; count=0 afterwards; the younger ALUs never commit.
- Two STOREs done at head -> they retire on consecutive cycles, never together.
- Lookup q_tag1=5 while cdb channel 1 writes tag 5 with 0xABCD -> q_ready1=1, q_value1=0xABCD in the same cycle.
- Hold rdy=0 for 3 cycles with done entries present -> no commit_valid; state unchanged when rdy returns.

Source files
------------

// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared kinds, entry record and helpers for the reorder buffer
package rob_pkg;

    typedef enum logic [1:0] {
        KIND_ALU    = 2'd0,
        KIND_LOAD   = 2'd1,
        KIND_STORE  = 2'd2,
        KIND_BRANCH = 2'd3
    } rob_kind_t;

    typedef struct packed {
        logic        valid;
        logic        done;
        rob_kind_t   kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred_npc;
        logic [31:0] npc;
    } rob_entry_t;

    // Counter increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/rob_cdb_match.sv
// rtl/rob_cdb_match.sv - N_CDB-way tag comparator returning hit and selected channel data
module rob_cdb_match #(
    parameter int N_CDB     = 2,
    parameter int TAG_W     = 4,
    parameter int DATA_W    = 32,
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [TAG_W-1:0]        tag,
    input  logic [N_CDB-1:0]        cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [N_CDB*DATA_W-1:0] cdb_data,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    // Later iterations override earlier ones, so the walk order sets channel priority
    always_comb begin
        int ch;
        ch   = 0;
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < N_CDB; i++) begin
            ch = LOW_FIRST ? (N_CDB - 1 - i) : i;
            if (cdb_valid[ch] && (cdb_tag[ch*TAG_W +: TAG_W] == tag)) begin
                hit  = 1'b1;
                data = cdb_data[ch*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/rob_multi.sv
// rtl/rob_multi.sv - multi-commit reorder buffer; ROB_PERF_CNT_EN adds saturating perf counters
module rob_multi
    import rob_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int N_CDB    = 2,
    parameter int COMMIT_W = 2,
    parameter int TAG_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    output logic [TAG_W-1:0]          issue_tag,
    input  logic [1:0]                issue_kind,
    input  logic [4:0]                issue_rd,
    input  logic [31:0]               issue_pred_npc,
    input  logic                      issue_done,
    input  logic [31:0]               issue_value,
    input  logic [N_CDB-1:0]          cdb_valid,
    input  logic [N_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [N_CDB*32-1:0]       cdb_value,
    input  logic [N_CDB*32-1:0]       cdb_npc,
    output logic [TAG_W-1:0]          head_tag,
    output logic [COMMIT_W-1:0]       commit_valid,
    output logic [COMMIT_W*TAG_W-1:0] commit_tag,
    output logic [COMMIT_W*5-1:0]     commit_rd,
    output logic [COMMIT_W*32-1:0]    commit_value,
    input  logic [TAG_W-1:0]          q_tag1,
    input  logic [TAG_W-1:0]          q_tag2,
    output logic                      q_ready1,
    output logic                      q_ready2,
    output logic [31:0]               q_value1,
    output logic [31:0]               q_value2,
    output logic                      flush,
    output logic [31:0]               redirect_pc
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]               perf_commits,
    output logic [31:0]               perf_flushes,
    output logic [31:0]               perf_full_cycles
`endif
);

    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    rob_entry_t              ent [DEPTH];
    logic [TAG_W-1:0]        head, tail, head1;
    logic [TAG_W:0]          count;
    rob_entry_t              e0, e1;
    logic                    fire0, fire1, mis0, mis1, issue_fire;
    logic [1:0]              n_commit;
    logic [DEPTH-1:0]        retiring, wb_hit;
    logic [63:0]             wb_data [DEPTH];
    logic [N_CDB*64-1:0]     cdb_wb;
    logic                    q1_hit, q2_hit;
    logic [31:0]             q1_fwd, q2_fwd;

    assign head1       = head + TAG_W'(1);
    assign e0          = ent[head];
    assign e1          = ent[head1];
    assign head_tag    = head;
    assign issue_tag   = tail;
    assign issue_ready = (count != FULL_CNT) && !flush;
    assign issue_fire  = rdy && issue_valid && issue_ready;

    // Retire selection; npc starts equal to pred_npc, so only a differing resolution redirects
    always_comb begin
        fire0 = rdy && e0.valid && e0.done;
        mis0  = fire0 && (e0.pred_npc != e0.npc);
        fire1 = 1'b0;
        if (COMMIT_W == 2)
            fire1 = fire0 && !mis0 && e1.valid && e1.done &&
                    !((e0.kind == KIND_STORE) && (e1.kind == KIND_STORE));
        mis1     = fire1 && (e1.pred_npc != e1.npc);
        n_commit = {1'b0, fire0} + {1'b0, fire1};
    end

    // Commit ports, flush strobe and redirect target
    always_comb begin
        commit_valid    = '0;
        commit_tag      = '0;
        commit_rd       = '0;
        commit_value    = '0;
        commit_valid[0] = fire0;
        commit_tag[0 +: TAG_W] = head;
        commit_rd[0 +: 5]      = e0.rd;
        commit_value[0 +: 32]  = e0.value;
        if (COMMIT_W == 2) begin
            commit_valid[COMMIT_W-1]                    = fire1;
            commit_tag[(COMMIT_W-1)*TAG_W +: TAG_W]     = head1;
            commit_rd[(COMMIT_W-1)*5 +: 5]              = e1.rd;
            commit_value[(COMMIT_W-1)*32 +: 32]         = e1.value;
        end
        flush       = mis0 || mis1;
        redirect_pc = mis0 ? e0.npc : (mis1 ? e1.npc : 32'd0);
    end

    // Entries that leave this cycle; their writebacks are discarded
    always_comb begin
        retiring = '0;
        if (fire0) retiring[head]  = 1'b1;
        if (fire1) retiring[head1] = 1'b1;
    end

    // Pair each channel's npc with its value so one comparator selects both
    always_comb begin
        for (int c = 0; c < N_CDB; c++)
            cdb_wb[c*64 +: 64] = {cdb_npc[c*32 +: 32], cdb_value[c*32 +: 32]};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_wb
        rob_cdb_match #(.N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(64), .LOW_FIRST(1'b0)) u_wb (
            .tag(TAG_W'(g)), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
            .cdb_data(cdb_wb), .hit(wb_hit[g]), .data(wb_data[g])
        );
    end

    rob_cdb_match #(.N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(32), .LOW_FIRST(1'b1)) u_q1 (
        .tag(q_tag1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_value), .hit(q1_hit), .data(q1_fwd)
    );

    rob_cdb_match #(.N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(32), .LOW_FIRST(1'b1)) u_q2 (
        .tag(q_tag2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_value), .hit(q2_hit), .data(q2_fwd)
    );

    // Operand lookup: stored result first, then same-cycle broadcast
    always_comb begin
        q_ready1 = 1'b0;
        q_value1 = '0;
        q_ready2 = 1'b0;
        q_value2 = '0;
        if (ent[q_tag1].valid && ent[q_tag1].done) begin
            q_ready1 = 1'b1;
            q_value1 = ent[q_tag1].value;
        end else if (q1_hit) begin
            q_ready1 = 1'b1;
            q_value1 = q1_fwd;
        end
        if (ent[q_tag2].valid && ent[q_tag2].done) begin
            q_ready2 = 1'b1;
            q_value2 = ent[q_tag2].value;
        end else if (q2_hit) begin
            q_ready2 = 1'b1;
            q_value2 = q2_fwd;
        end
    end

    // Buffer state: flush wipes everything, otherwise writeback, retire and issue
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent[i].valid <= 1'b0;
                    ent[i].done  <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (retiring[i]) begin
                        ent[i].valid <= 1'b0;
                        ent[i].done  <= 1'b0;
                    end else if (wb_hit[i] && ent[i].valid) begin
                        ent[i].done  <= 1'b1;
                        ent[i].value <= wb_data[i][31:0];
                        ent[i].npc   <= wb_data[i][63:32];
                    end
                end
                if (issue_fire) begin
                    ent[tail].valid    <= 1'b1;
                    ent[tail].done     <= issue_done;
                    ent[tail].kind     <= rob_kind_t'(issue_kind);
                    ent[tail].rd       <= ((issue_kind == KIND_STORE) || (issue_kind == KIND_BRANCH))
                                          ? 5'd0 : issue_rd;
                    ent[tail].value    <= issue_value;
                    ent[tail].pred_npc <= issue_pred_npc;
                    ent[tail].npc      <= issue_pred_npc;
                end
                head  <= head + TAG_W'(n_commit);
                tail  <= tail + TAG_W'(issue_fire);
                count <= count + (TAG_W+1)'(issue_fire) - (TAG_W+1)'(n_commit);
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Saturating activity counters, frozen with the rest of the state while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits     <= '0;
            perf_flushes     <= '0;
            perf_full_cycles <= '0;
        end else if (rdy) begin
            perf_commits     <= sat_add(perf_commits, n_commit);
            perf_flushes     <= sat_add(perf_flushes, {1'b0, flush});
            perf_full_cycles <= sat_add(perf_full_cycles, {1'b0, (count == FULL_CNT) && issue_valid});
        end
    end
`endif

endmodule

// File: tb/tb_rob_multi.sv
// tb/tb_rob_multi.sv - directed and randomized bench for rob_multi against a queue model
module tb_rob_multi;

    localparam int DEPTH = 16, N_CDB = 2, COMMIT_W = 2, TAG_W = 4;

    logic                      clk = 1'b0;
    logic                      rst, rdy, issue_valid, issue_done;
    logic                      issue_ready;
    logic [TAG_W-1:0]          issue_tag, head_tag, q_tag1, q_tag2;
    logic [1:0]                issue_kind;
    logic [4:0]                issue_rd;
    logic [31:0]               issue_pred_npc, issue_value;
    logic [N_CDB-1:0]          cdb_valid;
    logic [N_CDB*TAG_W-1:0]    cdb_tag;
    logic [N_CDB*32-1:0]       cdb_value, cdb_npc;
    logic [COMMIT_W-1:0]       commit_valid;
    logic [COMMIT_W*TAG_W-1:0] commit_tag;
    logic [COMMIT_W*5-1:0]     commit_rd;
    logic [COMMIT_W*32-1:0]    commit_value;
    logic                      q_ready1, q_ready2, flush;
    logic [31:0]               q_value1, q_value2, redirect_pc;
`ifdef ROB_PERF_CNT_EN
    logic [31:0]               perf_commits, perf_flushes, perf_full_cycles;
`endif

    always #5 clk = ~clk;

    rob_multi #(.DEPTH(DEPTH), .N_CDB(N_CDB), .COMMIT_W(COMMIT_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_tag(issue_tag),
        .issue_kind(issue_kind), .issue_rd(issue_rd), .issue_pred_npc(issue_pred_npc),
        .issue_done(issue_done), .issue_value(issue_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_npc(cdb_npc),
        .head_tag(head_tag), .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_rd(commit_rd), .commit_value(commit_value),
        .q_tag1(q_tag1), .q_tag2(q_tag2), .q_ready1(q_ready1), .q_ready2(q_ready2),
        .q_value1(q_value1), .q_value2(q_value2),
        .flush(flush), .redirect_pc(redirect_pc)
`ifdef ROB_PERF_CNT_EN
        , .perf_commits(perf_commits), .perf_flushes(perf_flushes),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    typedef struct {
        int          tag;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] pred;
        logic [31:0] npc;
        bit          done;
    } m_ent_t;

    m_ent_t mq[$];
    int     m_tail;
    int     n_checks = 0, n_pass = 0;
    bit     e_flush, e_ready;
    int     e_ncommit;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void m_lookup(input logic [TAG_W-1:0] t, output bit r, output logic [31:0] v);
        r = 0;
        v = '0;
        foreach (mq[i]) if (mq[i].tag == int'(t) && mq[i].done) begin r = 1; v = mq[i].value; end
        for (int c = 0; c < N_CDB; c++)
            if (!r && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == t) begin
                r = 1;
                v = cdb_value[c*32 +: 32];
            end
    endfunction

    task automatic compare_model();
        int          n;
        bit          c0, c1, m0, m1, r;
        logic [31:0] v, rp;
        n = mq.size();
        c0 = 0; c1 = 0; m0 = 0; m1 = 0; rp = '0;
        if (rdy && n >= 1 && mq[0].done) begin
            c0 = 1;
            m0 = mq[0].pred != mq[0].npc;
        end
        if (c0 && !m0 && n >= 2 && mq[1].done && !(mq[0].kind == 2 && mq[1].kind == 2)) begin
            c1 = 1;
            m1 = mq[1].pred != mq[1].npc;
        end
        if (m0) rp = mq[0].npc;
        else if (m1) rp = mq[1].npc;
        e_flush   = m0 || m1;
        e_ready   = (n < DEPTH) && !e_flush;
        e_ncommit = int'(c0) + int'(c1);
        chk("issue_ready", issue_ready, e_ready);
        chk("issue_tag", issue_tag, m_tail);
        chk("head_tag", head_tag, (m_tail - n + DEPTH) % DEPTH);
        chk("commit_valid", commit_valid, {c1, c0});
        chk("flush", flush, e_flush);
        chk("redirect_pc", redirect_pc, rp);
        if (c0) begin
            chk("commit_tag0", commit_tag[0 +: TAG_W], mq[0].tag);
            chk("commit_rd0", commit_rd[0 +: 5], mq[0].rd);
            chk("commit_value0", commit_value[0 +: 32], mq[0].value);
        end
        if (c1) begin
            chk("commit_tag1", commit_tag[TAG_W +: TAG_W], mq[1].tag);
            chk("commit_rd1", commit_rd[5 +: 5], mq[1].rd);
            chk("commit_value1", commit_value[32 +: 32], mq[1].value);
        end
        m_lookup(q_tag1, r, v);
        chk("q_ready1", q_ready1, r);
        chk("q_value1", q_value1, v);
        m_lookup(q_tag2, r, v);
        chk("q_ready2", q_ready2, r);
        chk("q_value2", q_value2, v);
    endtask

    task automatic update_model();
        m_ent_t e;
        if (rst) begin
            mq.delete();
            m_tail = 0;
        end else if (rdy) begin
            if (e_flush) begin
                mq.delete();
                m_tail = 0;
            end else begin
                repeat (e_ncommit) void'(mq.pop_front());
                for (int c = 0; c < N_CDB; c++)
                    if (cdb_valid[c])
                        foreach (mq[i])
                            if (mq[i].tag == int'(cdb_tag[c*TAG_W +: TAG_W])) begin
                                mq[i].done  = 1;
                                mq[i].value = cdb_value[c*32 +: 32];
                                mq[i].npc   = cdb_npc[c*32 +: 32];
                            end
                if (issue_valid && e_ready) begin
                    e.tag   = m_tail;
                    e.kind  = issue_kind;
                    e.rd    = (issue_kind >= 2) ? 5'd0 : issue_rd;
                    e.value = issue_value;
                    e.pred  = issue_pred_npc;
                    e.npc   = issue_pred_npc;
                    e.done  = issue_done;
                    mq.push_back(e);
                    m_tail = (m_tail + 1) % DEPTH;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        compare_model();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; issue_valid = 0; issue_kind = 0; issue_rd = 0;
        issue_pred_npc = 0; issue_done = 0; issue_value = 0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_npc = '0;
        q_tag1 = 0; q_tag2 = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        mq.delete();
        m_tail = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic set_issue(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pred,
                             input logic dn, input logic [31:0] val);
        issue_valid = 1; issue_kind = k; issue_rd = rd;
        issue_pred_npc = pred; issue_done = dn; issue_value = val;
    endtask

    task automatic set_wb(input int c, input logic [TAG_W-1:0] t, input logic [31:0] val,
                          input logic [31:0] npc);
        cdb_valid[c] = 1'b1;
        cdb_tag[c*TAG_W +: TAG_W] = t;
        cdb_value[c*32 +: 32] = val;
        cdb_npc[c*32 +: 32] = npc;
    endtask

    initial begin
        int idx;
        do_reset();
        #1;
        chk("rst_issue_ready", issue_ready, 1);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);
        chk("rst_head_tag", head_tag, 0);

        // Out-of-order writeback, in-order dual retire
        for (int i = 0; i < 3; i++) begin idle(); set_issue(0, 5'(i + 1), 32'h4, 0, 0); step(); end
        idle(); set_wb(0, 2, 32'h33, 32'h4); step();
        idle(); set_wb(0, 0, 32'h11, 32'h4); set_wb(1, 1, 32'h22, 32'h4); step();
        idle(); #1;
        chk("ooo_dual_valid", commit_valid, 2'b11);
        chk("ooo_val0", commit_value[0 +: 32], 32'h11);
        chk("ooo_val1", commit_value[32 +: 32], 32'h22);
        step();
        idle(); #1;
        chk("ooo_last_valid", commit_valid, 2'b01);
        chk("ooo_last_val", commit_value[0 +: 32], 32'h33);
        step();

        // Fill to capacity, free one slot, tail wraps
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin idle(); set_issue(0, 5'd3, 32'h4, 0, 0); step(); end
        idle(); #1;
        chk("full_not_ready", issue_ready, 0);
        step();
        idle(); set_wb(0, 0, 32'h55, 32'h4); step();
        idle(); #1;
        chk("full_one_retire", commit_valid, 2'b01);
        chk("full_still_blocked", issue_ready, 0);
        step();
        idle(); #1;
        chk("full_ready_again", issue_ready, 1);
        chk("full_tail_wrap", issue_tag, 0);
        set_issue(0, 5'd4, 32'h4, 0, 0);
        step();
        idle(); #1;
        chk("full_head_after", head_tag, 1);
        chk("full_tail_after", issue_tag, 1);
        step();

        // Branch mispredict flushes younger entries
        do_reset();
        idle(); set_issue(3, 5'd7, 32'h100, 0, 0); step();
        for (int i = 0; i < 2; i++) begin idle(); set_issue(0, 5'd9, 32'h4, 0, 0); step(); end
        idle(); set_wb(0, 1, 32'hA1, 32'h4); set_wb(1, 2, 32'hA2, 32'h4); step();
        idle(); set_wb(0, 0, 32'h0, 32'h200); step();
        idle(); #1;
        chk("br_flush", flush, 1);
        chk("br_redirect", redirect_pc, 32'h200);
        chk("br_commit_valid", commit_valid, 2'b01);
        chk("br_rd_zero", commit_rd[0 +: 5], 0);
        step();
        idle(); #1;
        chk("br_tail_clear", issue_tag, 0);
        chk("br_head_clear", head_tag, 0);
        chk("br_no_young_commit", commit_valid, 0);
        step();
        step();

        // Two stores at head retire one per cycle
        do_reset();
        for (int i = 0; i < 2; i++) begin idle(); set_issue(2, 5'd5, 32'h4, 0, 0); step(); end
        idle(); set_wb(0, 0, 32'h1, 32'h4); set_wb(1, 1, 32'h2, 32'h4); step();
        idle(); #1;
        chk("st_first", commit_valid, 2'b01);
        step();
        idle(); #1;
        chk("st_second", commit_valid, 2'b01);
        step();

        // Same-cycle forwarding from channel 1
        do_reset();
        for (int i = 0; i < 6; i++) begin idle(); set_issue(1, 5'd6, 32'h4, 0, 0); step(); end
        idle(); q_tag1 = 5; set_wb(1, 5, 32'hABCD, 32'h4); #1;
        chk("fwd_ready", q_ready1, 1);
        chk("fwd_value", q_value1, 32'hABCD);
        step();

        // rdy low freezes retirement
        do_reset();
        for (int i = 0; i < 2; i++) begin idle(); set_issue(0, 5'd8, 32'h4, 0, 0); step(); end
        idle(); set_wb(0, 0, 32'hC0, 32'h4); set_wb(1, 1, 32'hC1, 32'h4); step();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy = 0; #1;
            chk("rdy_hold_commit", commit_valid, 0);
            step();
        end
        idle(); #1;
        chk("rdy_resume_commit", commit_valid, 2'b11);
        chk("rdy_resume_head", head_tag, 0);
        step();

        // Randomized traffic against the model, with a reset mid-stream
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            if (cyc == 2000) rst = 1;
            if ($urandom_range(0, 2) != 0)
                set_issue(2'($urandom), 5'($urandom), $urandom & 32'hFFFF_FFFC,
                          ($urandom_range(0, 3) == 0), $urandom);
            for (int c = 0; c < N_CDB; c++) begin
                if ($urandom_range(0, 1) == 1) begin
                    logic [TAG_W-1:0] t;
                    logic [31:0]      np;
                    if (mq.size() > 0 && $urandom_range(0, 9) != 0) begin
                        idx = $urandom_range(0, mq.size() - 1);
                        t   = TAG_W'(mq[idx].tag);
                        np  = ($urandom_range(0, 24) == 0) ? $urandom : mq[idx].pred;
                    end else begin
                        t  = TAG_W'($urandom);
                        np = $urandom;
                    end
                    if (c == 0 || !cdb_valid[0] || cdb_tag[0 +: TAG_W] != t)
                        set_wb(c, t, $urandom, np);
                end
            end
            q_tag1 = TAG_W'($urandom);
            q_tag2 = TAG_W'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
